// File: rtl/win33_tile_sched.sv
// rtl/win33_tile_sched.sv - Winograd F(2x2,3x3) tile scheduler
// Walks the input map in 4x4 stride-2 tiles: fetch, fire engine, wait, hand off result.
module win33_tile_sched #(
  parameter int FMAP_W  = 32,
  parameter int FMAP_H  = 32,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cfg_bitwidth,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              act_req,
  output logic [ADDR_W-1:0] act_row,
  output logic [ADDR_W-1:0] act_col,
  input  logic              act_ack,
  output logic              win_enable,
  output logic [1:0]        win_bitwidth,
  input  logic              win_done,
  input  logic [127:0]      win_f,
  output logic              out_valid,
  output logic [127:0]      out_data,
  output logic [ADDR_W-1:0] out_idx,
  input  logic              out_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FIRE, S_WAIT, S_WRITE, S_ADVANCE, S_DONE
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The counter starts at 0 in the first WAIT cycle; ending at TIMEOUT-2 makes
  // err_timeout rise exactly TIMEOUT cycles after the win_enable pulse.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 2);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(FMAP_W - 4);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(FMAP_H - 4);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [1:0]          bw_q, bw_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [127:0]        data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bw_q    <= 2'b00;
      err_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bw_q    <= bw_d;
      err_q   <= err_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bw_d    = bw_q;
    err_d   = err_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bw_d    = cfg_bitwidth;
          err_d   = 1'b0;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (act_ack) state_d = S_FIRE;
      end
      S_FIRE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the final wait cycle still beats the timeout.
        if (win_done) begin
          data_d  = win_f;
          state_d = S_WRITE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (out_ready) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        idx_d = idx_q + ONE;
        if (row_q == ROW_LAST && col_q == COL_LAST) begin
          state_d = S_DONE;
        end else begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + STEP;
          end else begin
            col_d = col_q + STEP;
          end
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign act_req      = (state_q == S_FETCH);
  assign win_enable   = (state_q == S_FIRE);
  assign out_valid    = (state_q == S_WRITE);
  assign err_timeout  = err_q;
  assign act_row      = row_q;
  assign act_col      = col_q;
  assign win_bitwidth = bw_q;
  assign out_data     = data_q;
  assign out_idx      = idx_q;

endmodule

// File: tb/tb_win33_tile_sched.sv
// tb/tb_win33_tile_sched.sv - directed self-checking bench for win33_tile_sched
// 8x8 map (3x3 tiles); engine model answers 3 cycles after enable.
module tb_win33_tile_sched;

  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    cfg_bitwidth;
  logic          busy;
  logic          done;
  logic          err_timeout;
  logic          act_req;
  logic [AW-1:0] act_row;
  logic [AW-1:0] act_col;
  logic          act_ack;
  logic          win_enable;
  logic [1:0]    win_bitwidth;
  logic          win_done;
  logic [127:0]  win_f;
  logic          out_valid;
  logic [127:0]  out_data;
  logic [AW-1:0] out_idx;
  logic          out_ready;

  win33_tile_sched #(
    .FMAP_W(8), .FMAP_H(8), .ADDR_W(AW), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_bitwidth(cfg_bitwidth),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .act_req(act_req), .act_row(act_row), .act_col(act_col), .act_ack(act_ack),
    .win_enable(win_enable), .win_bitwidth(win_bitwidth),
    .win_done(win_done), .win_f(win_f),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int fetch_n, en_n, acc_n, done_n, stall_n, hold_cnt;
  int eng_cnt, eng_idx;
  int start_cyc, done_cyc, en_cyc, err_cyc;
  bit engine_on, spur_en, hold_en, prev_fire, fire, prev_err;
  logic [1:0] exp_bw;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] pat(input int i);
    return {4{16'hBEEF, 16'(i)}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment (engine, handshakes) and per-cycle monitor share one process.
  always @(negedge clk) begin
    if (!rst_n) begin
      eng_cnt   = 0;
      win_done  = 1'b0;
      prev_fire = 1'b0;
    end else begin
      fire = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) fire = 1'b1;
      end
      win_done = fire || (spur_en && act_req);
      win_f    = fire ? pat(eng_idx) : {128{1'b1}};
      if (fire) eng_idx++;
      if (win_enable && engine_on) eng_cnt = 3;

      out_ready = 1'b1;
      if (hold_en && out_valid && out_idx == AW'(4) && hold_cnt < 5) begin
        out_ready = 1'b0;
        hold_cnt++;
      end

      if (prev_fire) chk("out_valid_after_win_done", out_valid, 1'b1);
      prev_fire = fire;
      if (act_req && act_ack) begin
        chk("act_row", act_row, AW'(2 * (fetch_n / 3)));
        chk("act_col", act_col, AW'(2 * (fetch_n % 3)));
        fetch_n++;
      end
      if (win_enable) begin
        chk("win_bitwidth", win_bitwidth, exp_bw);
        en_cyc = cyc;
        en_n++;
      end
      if (out_valid) begin
        chk("out_idx", out_idx, AW'(acc_n));
        chk("out_data", out_data, pat(acc_n));
        chk("no_fetch_or_fire_in_write", {act_req, win_enable}, 2'b00);
        if (out_ready) acc_n++;
        else stall_n++;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (err_timeout && !prev_err) err_cyc = cyc;
      prev_err = err_timeout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_init();
    fetch_n = 0; en_n = 0; acc_n = 0; done_n = 0; stall_n = 0; hold_cnt = 0;
    eng_cnt = 0; eng_idx = 0; done_cyc = -1; en_cyc = -1; err_cyc = -1;
  endtask

  task automatic start_frame(input logic [1:0] bw);
    frame_init();
    cfg_bitwidth = bw;
    exp_bw = bw;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("act_req_after_start", act_req, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_n != 0) break;
      tick();
    end
    chk("done_within_budget", done_n != 0, 1'b1);
  endtask

  task automatic end_checks(input int exp_cycles, input int exp_stalls);
    chk("tiles_out", acc_n, 9);
    chk("enables", en_n, 9);
    chk("fetches", fetch_n, 9);
    chk("done_pulses", done_n, 1);
    chk("frame_cycles", done_cyc - start_cyc, exp_cycles);
    chk("stall_cycles", stall_n, exp_stalls);
    chk("err_timeout_clear", err_timeout, 1'b0);
    chk("busy_after_done", busy, 1'b0);
    chk("final_out_idx", out_idx, AW'(9));
    chk("bitwidth_held", win_bitwidth, exp_bw);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {busy, done, err_timeout, act_req, act_row, act_col, win_enable,
              win_bitwidth, out_valid, out_data, out_idx}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_bitwidth = 2'b00; act_ack = 1'b1;
    out_ready = 1'b1; win_done = 1'b0; win_f = '0;
    engine_on = 1'b1; spur_en = 1'b0; hold_en = 1'b0; prev_err = 1'b0;
    exp_bw = 2'b00;
    frame_init();
    tick();
    check_all_zero("reset_outputs");
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("idle_after_reset");

    // Plain frame
    start_frame(2'b01);
    wait_done(200);
    end_checks(64, 0);

    // Backpressure, spurious win_done, start while busy, cfg change mid-frame
    hold_en = 1'b1;
    spur_en = 1'b1;
    start_frame(2'b10);
    for (int i = 0; i < 200 && acc_n < 2; i++) tick();
    start = 1'b1;
    cfg_bitwidth = 2'b01;
    tick();
    start = 1'b0;
    chk("bitwidth_mid_frame", win_bitwidth, 2'b10);
    wait_done(300);
    end_checks(69, 5);
    hold_en = 1'b0;
    spur_en = 1'b0;

    // Engine never completes
    engine_on = 1'b0;
    start_frame(2'b11);
    for (int i = 0; i < 400 && err_cyc < 0; i++) tick();
    chk("timeout_seen", err_cyc >= 0, 1'b1);
    chk("timeout_latency", err_cyc - en_cyc, 255);
    chk("timeout_done_same_cycle", done_cyc, err_cyc);
    chk("timeout_done_pulses", done_n, 1);
    chk("timeout_no_output", acc_n, 0);
    chk("timeout_busy_low", busy, 1'b0);
    chk("timeout_sticky", err_timeout, 1'b1);
    tick();
    chk("timeout_sticky_idle", err_timeout, 1'b1);
    engine_on = 1'b1;

    // Reset during WAIT of tile 2
    start_frame(2'b10);
    chk("err_cleared_by_start", err_timeout, 1'b0);
    for (int i = 0; i < 200 && en_n < 3; i++) tick();
    chk("reached_tile2_wait", en_n, 3);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_mid_frame");
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("idle_after_mid_reset");
    chk("no_done_on_abort", done_n, 0);

    // Clean restart from tile (0,0)
    start_frame(2'b10);
    wait_done(200);
    end_checks(64, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/win33_tile_sched.md
# win33_tile_sched

Tile scheduler for the Winograd F(2x2,3x3) engine. It walks a FMAP_H x FMAP_W input feature map in overlapping 4x4 input tiles at stride 2, and requests each tile's four activation rows from the buffer. It then fires one engine operation, waits for the engine's completion, and hands the 128-bit 2x2 output tile downstream with a valid/ready handshake. It sits between the line/activation buffer, the `win33` engine and the output writer, and drives the engine's `enable` and `bitwidth` inputs.

## Interface
- FMAP_W, 32: input map width in pixels; even, >= 4
- FMAP_H, 32: input map height in pixels; even, >= 4
- ADDR_W, 10: width of tile coordinate and output index fields
- TIMEOUT, 255: maximum cycles in WAIT before the scheduler aborts
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start request; sampled only in IDLE
- cfg_bitwidth  in  2  precision mode; latched on accepted start
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse in DONE
- err_timeout  out  1  sticky; set on timeout, cleared on next accepted start
- act_req  out  1  activation fetch request, held high in FETCH
- act_row  out  ADDR_W  top pixel row of the current tile
- act_col  out  ADDR_W  left pixel column of the current tile
- act_ack  in  1  buffer has act1..act4 stable at the engine inputs
- win_enable  out  1  one-cycle engine start pulse
- win_bitwidth  out  2  latched cfg_bitwidth, stable for the whole frame
- win_done  in  1  engine completion (end_signal_win33)
- win_f  in  128  engine output tile
- out_valid  out  1  output tile available
- out_data  out  128  win_f captured on win_done
- out_idx  out  ADDR_W  linear tile index, row-major, starting at 0
- out_ready  in  1  downstream accepts out_data

## Operation
- Tiles per row: TC = (FMAP_W-2)/2. Tiles per column: TR = (FMAP_H-2)/2. Total tiles: TR*TC.
- States:
  - IDLE: start=1 → latch cfg_bitwidth, clear coords, out_idx and err_timeout → FETCH.
  - FETCH: act_req=1, act_row/act_col stable. act_ack=1 → FIRE.
  - FIRE: win_enable=1 for exactly one cycle → WAIT; the wait counter clears.
  - WAIT: win_done=1 → capture win_f into out_data → WRITE. If the wait counter reaches TIMEOUT without win_done → set err_timeout → DONE.
  - WRITE: out_valid=1; out_data and out_idx held stable. out_ready=1 → ADVANCE.
  - ADVANCE: if act_col == FMAP_W-4, act_col←0 and act_row←act_row+2; otherwise act_col←act_col+2. out_idx←out_idx+1. If the tile just written was the last (act_row == FMAP_H-4 and act_col == FMAP_W-4) → DONE, with coords left unchanged; otherwise → FETCH.
  - DONE: done=1 → IDLE.
- start outside IDLE is ignored.
- win_done outside WAIT is ignored.
- act_ack outside FETCH is ignored.
- out_ready without out_valid has no effect.
- win_done and timeout in the same cycle: win_done wins.
- Reset values: every output 0, state IDLE, err_timeout 0, win_bitwidth 0.
- Asserting rst_n low mid-frame returns to IDLE immediately. No done pulse is produced and no partial state survives.

## Timing
- start sampled high in cycle 0 → FETCH and busy=1 in cycle 1.
- act_ack high in cycle n → win_enable high in cycle n+1.
- win_done high in cycle m → out_valid high and out_data valid in cycle m+1.
- out_ready sampled high in cycle k → out_valid low in k+1 (ADVANCE) → act_req high in k+2.
- Per-tile overhead beyond handshake waits: 4 cycles (FETCH with same-cycle ack, FIRE, WRITE with same-cycle ready, ADVANCE).
- done is high in the cycle after the final ADVANCE. busy drops in the cycle after done.
- out_valid must not drop before acceptance. out_data and out_idx must not change while out_valid=1.

## Test plan
- FMAP_W=FMAP_H=8, act_ack/out_ready tied high, engine model returns win_done 3 cycles after enable with win_f=tile index → 9 outputs, out_idx 0..8. (act_row,act_col) sequence (0,0),(0,2),(0,4),(2,0)…(4,4). done pulses once. err_timeout=0.
- Backpressure: hold out_ready low 5 cycles on tile 4 → out_valid held, out_data/out_idx stable. No win_enable until acceptance.
- Engine never asserts win_done, TIMEOUT=255 → err_timeout=1 exactly 255 cycles after win_enable. done pulse follows, then IDLE. The next start clears err_timeout.
- Spurious win_done in FETCH and start while busy → both ignored. Tile count still 9 and win_enable pulses exactly 9 times.
- rst_n pulsed low during WAIT of tile 2 → all outputs 0 asynchronously, state IDLE. A new start restarts from (0,0) with out_idx 0.
- cfg_bitwidth=2'b10 at start, changed to 2'b01 mid-frame → win_bitwidth remains 2'b10 for the whole frame.
